// File: rtl/data_io_wide_if.sv
// Bus bundle between the IO controller's SPI link, the write strobe
// source and the memory sink fed by data_io_wide.
interface data_io_wide_if #(
    parameter int DW     = 8,
    parameter int ADDR_W = 25
) ();
    logic              SPI_SCK;
    logic              SPI_SS2;
    logic              SPI_DI;
    logic              clkref;
    logic              ioctl_wait;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [DW-1:0]     ioctl_dout;
    logic [ADDR_W-1:0] ioctl_filesize;
    logic              overflow;

    modport master (
        input  SPI_SCK, SPI_SS2, SPI_DI, clkref, ioctl_wait,
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr,
               ioctl_dout, ioctl_filesize, overflow
    );

    modport slave (
        output SPI_SCK, SPI_SS2, SPI_DI, clkref, ioctl_wait,
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr,
               ioctl_dout, ioctl_filesize, overflow
    );
endinterface

// File: rtl/data_io_wide.sv
// SPI download receiver: deserialises command/payload bytes from the IO
// controller, packs them little-endian into DW-bit words, buffers them in a
// small FIFO and issues them to the sink one word per clkref-enabled cycle.
// overflow is a sticky flag for words lost to a full FIFO.
module data_io_wide #(
    parameter int DW         = 8,
    parameter int ADDR_W     = 25,
    parameter int START_ADDR = 0,
    parameter int FIFO_DEPTH = 4
) (
    input logic            clk_sys,
    input logic            reset,
    data_io_wide_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(DW / 8);

    typedef enum logic [1:0] {DL_IDLE, DL_ACTIVE, DL_DRAIN} dl_state_t;
    dl_state_t state, state_next;

    logic sck_meta, sck_sync, sck_prev;
    logic ss_meta, ss_sync, di_meta, di_sync;
    logic [1:0] sync_live;
    logic frame_block;
    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;
    logic [7:0] cmd, index_reg;
    logic cmd_valid;
    logic lane;
    logic [DW-1:0] word_buf;
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] next_addr, addr_q, filesize_q;
    logic [DW-1:0] dout_q;
    logic [7:0] index_q;
    logic wr_q, overflow_q;

    logic bit_edge, byte_done, start_evt, end_evt, data_evt, idx_evt;
    logic [7:0] rx_byte;
    logic lane_last, push_req, push_ok, pop, fifo_empty, fifo_full;
    logic [DW-1:0] word_next, push_data;

    // Bring the asynchronous SPI pins into clk_sys; sync_live marks when the
    // synchronised values reflect the pins rather than their reset values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            di_meta   <= 1'b0;
            di_sync   <= 1'b0;
            sync_live <= 2'b00;
        end else begin
            sck_meta  <= bus.SPI_SCK;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            ss_meta   <= bus.SPI_SS2;
            ss_sync   <= ss_meta;
            di_meta   <= bus.SPI_DI;
            di_sync   <= di_meta;
            sync_live <= {sync_live[0], 1'b1};
        end
    end

    // Decode SCK edges into byte events and the download-level actions they trigger.
    always_comb begin
        bit_edge   = sync_live[1] && sck_sync && !sck_prev && !ss_sync && !frame_block;
        rx_byte    = {shift_reg, di_sync};
        byte_done  = bit_edge && (bit_cnt == 3'd7);
        start_evt  = byte_done && cmd_valid && (cmd == 8'h53) && rx_byte[0];
        end_evt    = byte_done && cmd_valid && (cmd == 8'h53) && !rx_byte[0] && (state == DL_ACTIVE);
        data_evt   = byte_done && cmd_valid && (cmd == 8'h54) && (state == DL_ACTIVE);
        idx_evt    = byte_done && cmd_valid && (cmd == 8'h55);
        word_next  = word_buf;
        if (lane) word_next[DW-1:DW-8] = rx_byte;
        else      word_next[7:0] = rx_byte;
        lane_last  = (DW == 8) || lane;
        push_req   = (data_evt && lane_last) || (end_evt && lane);
        push_data  = end_evt ? word_buf : word_next;
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = ((wr_ptr - rd_ptr) == (PW+1)'(FIFO_DEPTH));
        pop        = bus.clkref && !bus.ioctl_wait && !fifo_empty && !start_evt;
        push_ok    = push_req && (!fifo_full || pop);
    end

    // Bit/byte framing; a reset mid-frame blocks bits until SS2 is seen high again.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            frame_block <= 1'b1;
            bit_cnt     <= 3'd0;
            shift_reg   <= 7'd0;
            cmd         <= 8'd0;
            cmd_valid   <= 1'b0;
            index_reg   <= 8'd0;
        end else begin
            if (sync_live[1] && ss_sync) begin
                frame_block <= 1'b0;
                bit_cnt     <= 3'd0;
                cmd         <= 8'd0;
                cmd_valid   <= 1'b0;
            end else if (bit_edge) begin
                shift_reg <= {shift_reg[5:0], di_sync};
                bit_cnt   <= bit_cnt + 3'd1;
                if (byte_done && !cmd_valid) begin
                    cmd       <= rx_byte;
                    cmd_valid <= 1'b1;
                end
            end
            if (idx_evt) index_reg <= rx_byte;
        end
    end

    // Download state register.
    always_ff @(posedge clk_sys) begin
        if (reset) state <= DL_IDLE;
        else       state <= state_next;
    end

    // Download sequencing: active until the end command, then drain until the sink has every word.
    always_comb begin
        state_next = state;
        case (state)
            DL_ACTIVE: if (end_evt) state_next = DL_DRAIN;
            DL_DRAIN:  if (fifo_empty && !wr_q) state_next = DL_IDLE;
            default:   ;
        endcase
        if (start_evt) state_next = DL_ACTIVE;
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_sys) begin
        if (push_ok) mem[wr_ptr[PW-1:0]] <= push_data;
    end

    // Word packing, FIFO pointers, output issue and download bookkeeping.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            lane       <= 1'b0;
            word_buf   <= '0;
            filesize_q <= '0;
            index_q    <= 8'd0;
            overflow_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            next_addr  <= START;
            addr_q     <= START;
            dout_q     <= '0;
            wr_q       <= 1'b0;
        end else begin
            wr_q <= pop;
            if (pop) begin
                dout_q    <= mem[rd_ptr[PW-1:0]];
                addr_q    <= next_addr;
                next_addr <= next_addr + STEP;
                rd_ptr    <= rd_ptr + 1'b1;
            end
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (push_req && !push_ok) overflow_q <= 1'b1;
            if (data_evt) begin
                filesize_q <= filesize_q + 1'b1;
                if (lane_last) begin
                    lane     <= 1'b0;
                    word_buf <= '0;
                end else begin
                    lane     <= 1'b1;
                    word_buf <= word_next;
                end
            end
            if (end_evt) begin
                lane     <= 1'b0;
                word_buf <= '0;
            end
            if (start_evt) begin
                index_q    <= index_reg;
                filesize_q <= '0;
                lane       <= 1'b0;
                word_buf   <= '0;
                overflow_q <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                next_addr  <= START;
            end
        end
    end

    assign bus.ioctl_download = (state != DL_IDLE);
    assign bus.ioctl_index    = index_q;
    assign bus.ioctl_wr       = wr_q;
    assign bus.ioctl_addr     = addr_q;
    assign bus.ioctl_dout     = dout_q;
    assign bus.ioctl_filesize = filesize_q;
    assign bus.overflow       = overflow_q;
endmodule

// File: tb/tb_data_io_wide.sv
// Bench for data_io_wide: three instances (8-bit, 16-bit, 4-bit wrapping
// address) share one SPI stream; a byte-level model predicts every write.
module tb_data_io_wide;
    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] dout;
    } wr_t;

    logic clk, reset;
    logic spi_sck, spi_ss2, spi_di, clkref, wait_in;
    int checks = 0;
    int errors = 0;
    int wait_hi = 0;
    int cyc = 0;
    bit prev_dl [3];
    logic [7:0] tx [8];

    wr_t exp0[$], exp1[$], exp2[$];
    wr_t log0[$], log1[$], log2[$];

    // model state: bytes -> words -> addresses
    bit m_active, m_wait_held;
    int m_issued [3];
    int m_held [3];
    bit m_pend [3];
    logic [7:0] m_lo [3];
    int m_dwb [3] = '{1, 2, 1};
    int m_start [3] = '{0, 0, 14};
    int m_mask [3] = '{32'h01FF_FFFF, 32'h01FF_FFFF, 15};
    int m_depth = 4;

    data_io_wide_if #(.DW(8),  .ADDR_W(25)) bus_a ();
    data_io_wide_if #(.DW(16), .ADDR_W(25)) bus_b ();
    data_io_wide_if #(.DW(8),  .ADDR_W(4))  bus_c ();

    data_io_wide #(.DW(8),  .ADDR_W(25), .START_ADDR(0),  .FIFO_DEPTH(4)) dut_a (.clk_sys(clk), .reset(reset), .bus(bus_a));
    data_io_wide #(.DW(16), .ADDR_W(25), .START_ADDR(0),  .FIFO_DEPTH(4)) dut_b (.clk_sys(clk), .reset(reset), .bus(bus_b));
    data_io_wide #(.DW(8),  .ADDR_W(4),  .START_ADDR(14), .FIFO_DEPTH(4)) dut_c (.clk_sys(clk), .reset(reset), .bus(bus_c));

    assign bus_a.SPI_SCK = spi_sck; assign bus_a.SPI_SS2 = spi_ss2; assign bus_a.SPI_DI = spi_di;
    assign bus_a.clkref = clkref;   assign bus_a.ioctl_wait = wait_in;
    assign bus_b.SPI_SCK = spi_sck; assign bus_b.SPI_SS2 = spi_ss2; assign bus_b.SPI_DI = spi_di;
    assign bus_b.clkref = clkref;   assign bus_b.ioctl_wait = wait_in;
    assign bus_c.SPI_SCK = spi_sck; assign bus_c.SPI_SS2 = spi_ss2; assign bus_c.SPI_DI = spi_di;
    assign bus_c.clkref = clkref;   assign bus_c.ioctl_wait = wait_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // clkref strobe every 4th cycle
    initial begin
        clkref = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            clkref = ((cyc % 4) == 0);
            cyc++;
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic exp_push(input int i, input wr_t e);
        case (i)
            0: exp0.push_back(e);
            1: exp1.push_back(e);
            default: exp2.push_back(e);
        endcase
    endtask

    function automatic int exp_size(input int i);
        case (i)
            0: return exp0.size();
            1: return exp1.size();
            default: return exp2.size();
        endcase
    endfunction

    task automatic exp_pop(input int i, output wr_t e);
        case (i)
            0: e = exp0.pop_front();
            1: e = exp1.pop_front();
            default: e = exp2.pop_front();
        endcase
    endtask

    task automatic log_push(input int i, input wr_t e);
        case (i)
            0: log0.push_back(e);
            1: log1.push_back(e);
            default: log2.push_back(e);
        endcase
    endtask

    function automatic int log_size(input int i);
        case (i)
            0: return log0.size();
            1: return log1.size();
            default: return log2.size();
        endcase
    endfunction

    function automatic wr_t log_at(input int i, input int k);
        wr_t bad;
        bad = '1;
        if (k >= log_size(i)) return bad;
        case (i)
            0: return log0[k];
            1: return log1[k];
            default: return log2[k];
        endcase
    endfunction

    task automatic log_clear();
        log0.delete(); log1.delete(); log2.delete();
    endtask

    task automatic model_word(input int i, input logic [15:0] w);
        wr_t e;
        if (m_wait_held) begin
            if (m_held[i] >= m_depth) return;
            m_held[i]++;
        end
        e.addr = 32'((m_start[i] + m_issued[i] * m_dwb[i]) & m_mask[i]);
        e.dout = w;
        exp_push(i, e);
        m_issued[i]++;
    endtask

    task automatic model_start();
        m_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_issued[i] = 0; m_held[i] = 0; m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_active) return;
        for (int i = 0; i < 3; i++) begin
            if (m_dwb[i] == 1) model_word(i, {8'h00, b});
            else if (!m_pend[i]) begin
                m_lo[i] = b; m_pend[i] = 1'b1;
            end else begin
                model_word(i, {b, m_lo[i]}); m_pend[i] = 1'b0;
            end
        end
    endtask

    task automatic model_end();
        if (!m_active) return;
        for (int i = 0; i < 3; i++)
            if (m_pend[i]) begin
                model_word(i, {8'h00, m_lo[i]}); m_pend[i] = 1'b0;
            end
        m_active = 1'b0;
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
    endtask

    task automatic model_payload(input logic [7:0] cmd, input logic [7:0] b);
        if (cmd == 8'h53) begin
            if (b[0]) model_start();
            else model_end();
        end else if (cmd == 8'h54) model_byte(b);
    endtask

    task automatic compare_inst(input int i, input string tag, input logic wr, input logic [31:0] addr,
                                input logic [15:0] dout, input logic dl);
        wr_t got, e;
        if (wr === 1'b1) begin
            got.addr = addr; got.dout = dout;
            log_push(i, got);
            if (wait_hi >= 2) check_output({tag, "_wr_while_wait"}, 64'd1, 64'd0);
            if (exp_size(i) == 0) check_output({tag, "_unexpected_wr"}, {16'h0, got}, 64'd0);
            else begin
                exp_pop(i, e);
                check_output({tag, "_wr"}, {16'h0, got}, {16'h0, e});
            end
        end
        if (prev_dl[i] && dl === 1'b0)
            check_output({tag, "_dl_fell_with_pending"}, 64'(exp_size(i)), 64'd0);
        prev_dl[i] = (dl === 1'b1);
    endtask

    // per-cycle comparison of every write against the model
    always @(negedge clk) begin
        compare_inst(0, "a", bus_a.ioctl_wr, 32'(bus_a.ioctl_addr), 16'(bus_a.ioctl_dout), bus_a.ioctl_download);
        compare_inst(1, "b", bus_b.ioctl_wr, 32'(bus_b.ioctl_addr), 16'(bus_b.ioctl_dout), bus_b.ioctl_download);
        compare_inst(2, "c", bus_c.ioctl_wr, 32'(bus_c.ioctl_addr), 16'(bus_c.ioctl_dout), bus_c.ioctl_download);
        if (wait_in) wait_hi++;
        else wait_hi = 0;
    end

    task automatic spi_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) begin
            spi_di = b[k];
            #40 spi_sck = 1'b1;
            #40 spi_sck = 1'b0;
        end
    endtask

    task automatic frame_open();
        spi_ss2 = 1'b0;
        #100;
    endtask

    task automatic frame_close();
        #100;
        spi_ss2 = 1'b1;
        #300;
    endtask

    task automatic frame_payload(input logic [7:0] cmd, input logic [7:0] b);
        model_payload(cmd, b);
        spi_byte(b);
    endtask

    task automatic apply_stimulus(input logic [7:0] cmd, input logic [7:0] b);
        frame_open();
        spi_byte(cmd);
        frame_payload(cmd, b);
        frame_close();
    endtask

    task automatic data_frame(input int n, input bit keep_low);
        frame_open();
        spi_byte(8'h54);
        for (int k = 0; k < n; k++) frame_payload(8'h54, tx[k]);
        if (!keep_low) frame_close();
    endtask

    task automatic check_state(input string tag, input logic dl, input logic [7:0] idx, input logic [31:0] fs);
        check_output({tag, "_a_dl"}, 64'(bus_a.ioctl_download), 64'(dl));
        check_output({tag, "_b_dl"}, 64'(bus_b.ioctl_download), 64'(dl));
        check_output({tag, "_c_dl"}, 64'(bus_c.ioctl_download), 64'(dl));
        check_output({tag, "_a_idx"}, 64'(bus_a.ioctl_index), 64'(idx));
        check_output({tag, "_b_idx"}, 64'(bus_b.ioctl_index), 64'(idx));
        check_output({tag, "_c_idx"}, 64'(bus_c.ioctl_index), 64'(idx));
        check_output({tag, "_a_fs"}, 64'(bus_a.ioctl_filesize), 64'(fs));
        check_output({tag, "_b_fs"}, 64'(bus_b.ioctl_filesize), 64'(fs));
        check_output({tag, "_c_fs"}, 64'(bus_c.ioctl_filesize), 64'(fs));
    endtask

    task automatic check_reset(input string tag);
        check_state(tag, 1'b0, 8'h00, 32'd0);
        check_output({tag, "_a_wr"}, 64'(bus_a.ioctl_wr), 64'd0);
        check_output({tag, "_b_wr"}, 64'(bus_b.ioctl_wr), 64'd0);
        check_output({tag, "_c_wr"}, 64'(bus_c.ioctl_wr), 64'd0);
        check_output({tag, "_a_addr"}, 64'(bus_a.ioctl_addr), 64'd0);
        check_output({tag, "_b_addr"}, 64'(bus_b.ioctl_addr), 64'd0);
        check_output({tag, "_c_addr"}, 64'(bus_c.ioctl_addr), 64'd14);
        check_output({tag, "_a_dout"}, 64'(bus_a.ioctl_dout), 64'd0);
        check_output({tag, "_b_dout"}, 64'(bus_b.ioctl_dout), 64'd0);
        check_output({tag, "_c_dout"}, 64'(bus_c.ioctl_dout), 64'd0);
    endtask

    task automatic check_log(input string name, input int i, input int k, input logic [31:0] addr, input logic [15:0] dout);
        wr_t e;
        e = log_at(i, k);
        check_output(name, {16'h0, e}, {16'h0, addr, dout});
    endtask

    task automatic check_pending(input string tag);
        check_output({tag, "_pend_a"}, 64'(exp_size(0)), 64'd0);
        check_output({tag, "_pend_b"}, 64'(exp_size(1)), 64'd0);
        check_output({tag, "_pend_c"}, 64'(exp_size(2)), 64'd0);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; spi_sck = 1'b0; spi_ss2 = 1'b1; spi_di = 1'b0; wait_in = 1'b0;
        m_wait_held = 1'b0;
        model_reset();
        settle(5);
        check_reset("rst");
        reset = 1'b0;
        settle(5);

        $display("[TB] index, start, three bytes, end");
        log_clear();
        apply_stimulus(8'h55, 8'h03);
        apply_stimulus(8'h53, 8'h01);
        check_output("t1_dl_active", 64'(bus_a.ioctl_download), 64'd1);
        tx[0] = 8'hA1; tx[1] = 8'hB2; tx[2] = 8'hC3;
        data_frame(3, 1'b0);
        apply_stimulus(8'h53, 8'h00);
        settle(60);
        check_state("t1", 1'b0, 8'h03, 32'd3);
        check_pending("t1");
        check_output("t1_a_count", 64'(log_size(0)), 64'd3);
        check_log("t1_a_w0", 0, 0, 32'd0, 16'h00A1);
        check_log("t1_a_w1", 0, 1, 32'd1, 16'h00B2);
        check_log("t1_a_w2", 0, 2, 32'd2, 16'h00C3);
        check_log("t1_b_w0", 1, 0, 32'd0, 16'hB2A1);
        check_log("t1_b_w1", 1, 1, 32'd2, 16'h00C3);
        check_log("t1_c_w2", 2, 2, 32'd0, 16'h00C3);

        $display("[TB] wide packing with odd byte count");
        log_clear();
        apply_stimulus(8'h53, 8'h01);
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
        data_frame(3, 1'b0);
        apply_stimulus(8'h53, 8'h00);
        settle(60);
        check_state("t2", 1'b0, 8'h03, 32'd3);
        check_pending("t2");
        check_output("t2_b_count", 64'(log_size(1)), 64'd2);
        check_log("t2_b_w0", 1, 0, 32'd0, 16'h2211);
        check_log("t2_b_w1", 1, 1, 32'd2, 16'h0033);

        $display("[TB] data outside a download");
        log_clear();
        tx[0] = 8'h77;
        data_frame(1, 1'b0);
        settle(40);
        check_state("t3", 1'b0, 8'h03, 32'd3);
        check_output("t3_a_count", 64'(log_size(0)), 64'd0);
        check_output("t3_a_ovf", 64'(bus_a.overflow), 64'd0);

        $display("[TB] backpressure with six bytes");
        log_clear();
        apply_stimulus(8'h53, 8'h01);
        @(negedge clk);
        wait_in = 1'b1;
        m_wait_held = 1'b1;
        for (int k = 0; k < 6; k++) tx[k] = 8'(k + 1);
        data_frame(6, 1'b0);
        apply_stimulus(8'h53, 8'h00);
        settle(20);
        check_output("t4_a_dl_held", 64'(bus_a.ioctl_download), 64'd1);
        check_output("t4_a_ovf", 64'(bus_a.overflow), 64'd1);
        check_output("t4_b_ovf", 64'(bus_b.overflow), 64'd0);
        check_output("t4_c_ovf", 64'(bus_c.overflow), 64'd1);
        check_output("t4_a_no_wr", 64'(log_size(0)), 64'd0);
        @(negedge clk);
        wait_in = 1'b0;
        m_wait_held = 1'b0;
        settle(60);
        check_state("t4", 1'b0, 8'h03, 32'd6);
        check_pending("t4");
        check_output("t4_a_count", 64'(log_size(0)), 64'd4);
        check_log("t4_a_w0", 0, 0, 32'd0, 16'h0001);
        check_log("t4_a_w3", 0, 3, 32'd3, 16'h0004);
        check_log("t4_c_w0", 2, 0, 32'd14, 16'h0001);
        check_log("t4_c_w1", 2, 1, 32'd15, 16'h0002);
        check_log("t4_c_w2", 2, 2, 32'd0, 16'h0003);
        check_log("t4_c_w3", 2, 3, 32'd1, 16'h0004);
        check_log("t4_b_w2", 1, 2, 32'd4, 16'h0605);

        $display("[TB] reset mid-transfer then fresh download");
        apply_stimulus(8'h53, 8'h01);
        tx[0] = 8'hC1; tx[1] = 8'hC2;
        data_frame(2, 1'b1);
        settle(30);
        check_pending("t5_pre");
        reset = 1'b1;
        model_reset();
        settle(3);
        reset = 1'b0;
        settle(4);
        check_reset("t5_rst");
        spi_byte(8'h53);
        spi_byte(8'h01);
        settle(20);
        check_output("t5_a_blocked", 64'(bus_a.ioctl_download), 64'd0);
        frame_close();
        log_clear();
        apply_stimulus(8'h53, 8'h01);
        tx[0] = 8'h5A;
        data_frame(1, 1'b0);
        apply_stimulus(8'h53, 8'h00);
        settle(60);
        check_state("t5", 1'b0, 8'h00, 32'd1);
        check_pending("t5");
        check_output("t5_a_count", 64'(log_size(0)), 64'd1);
        check_log("t5_a_w0", 0, 0, 32'd0, 16'h005A);
        check_log("t5_b_w0", 1, 0, 32'd0, 16'h005A);
        check_log("t5_c_w0", 2, 0, 32'd14, 16'h005A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
